// File: rtl/nf10_switch_input_arbiter_pkg.sv
// Shared definitions for the NetFPGA-10G switch input arbiter.
//   - TUSER field offsets (packet length, source port, destination port)
//   - number of ingress queues
//   - arbiter FSM encoding
//   - round-robin index helper
package nf10_switch_input_arbiter_pkg;

  localparam int NUM_QUEUES = 5;
  localparam int QID_W      = 3;

  localparam int LEN_POS = 0;
  localparam int SRC_POS = 16;
  localparam int DST_POS = 24;

  typedef enum logic {
    PICK = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // (base + offset) mod NUM_QUEUES; valid for base < NUM_QUEUES, offset <= NUM_QUEUES
  function automatic logic [QID_W-1:0] rr_index(input logic [QID_W-1:0] base,
                                                input logic [QID_W-1:0] offset);
    logic [QID_W:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= (QID_W+1)'(NUM_QUEUES)) sum = sum - (QID_W+1)'(NUM_QUEUES);
    return sum[QID_W-1:0];
  endfunction

endpackage

// File: rtl/nf10_axis_fallthrough_fifo.sv
// First-word-fall-through FIFO used to buffer one ingress port.
//   i_clk / i_rst_n : clock, async active-low reset (clears pointers only)
//   i_wr_en, i_wr_data : write request and word
//   i_rd_en            : pop the current head
//   o_rd_data          : current head word (valid while !o_empty)
//   o_full, o_empty    : occupancy flags
// A write while full is accepted when a pop happens in the same cycle.
module nf10_axis_fallthrough_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_BITS:0] r_wr_ptr;
  logic [DEPTH_BITS:0] r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  // extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                   (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);

  assign w_pop  = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

endmodule

// File: rtl/nf10_switch_input_arbiter.sv
// Merges five AXI4-Stream ingress ports (4 MAC + 1 DMA) into one stream feeding
// output-port lookup. Each port has its own FIFO; packets are granted whole in
// round-robin order, TUSER passes through untouched.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXIS_{0..4}_*            : ingress streams, TREADY = FIFO not full
//   M_AXIS_*                   : merged egress stream
//   STAT_PKT_CNT               : packets sent (only with INPUT_ARB_STATS_EN)
// Optional feature macro: INPUT_ARB_STATS_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// PICK  | idle gap; scan queues after last_grant for a non-empty one
// SEND  | stream granted queue head until a TLAST word is accepted
module nf10_switch_input_arbiter
  import nf10_switch_input_arbiter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_0_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_0_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_0_TUSER,
  input  logic                              S_AXIS_0_TVALID,
  output logic                              S_AXIS_0_TREADY,
  input  logic                              S_AXIS_0_TLAST,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_1_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_1_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_1_TUSER,
  input  logic                              S_AXIS_1_TVALID,
  output logic                              S_AXIS_1_TREADY,
  input  logic                              S_AXIS_1_TLAST,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_2_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_2_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_2_TUSER,
  input  logic                              S_AXIS_2_TVALID,
  output logic                              S_AXIS_2_TREADY,
  input  logic                              S_AXIS_2_TLAST,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_3_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_3_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_3_TUSER,
  input  logic                              S_AXIS_3_TVALID,
  output logic                              S_AXIS_3_TREADY,
  input  logic                              S_AXIS_3_TLAST,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_4_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_4_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_4_TUSER,
  input  logic                              S_AXIS_4_TVALID,
  output logic                              S_AXIS_4_TREADY,
  input  logic                              S_AXIS_4_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST
`ifdef INPUT_ARB_STATS_EN
  ,
  output logic [31:0]                       STAT_PKT_CNT
`endif
);

  localparam int W_WORD = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_TUSER_WIDTH + 1;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   w_s_tdata [NUM_QUEUES];
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] w_s_tstrb [NUM_QUEUES];
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  w_s_tuser [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]            w_s_tvalid;
  logic [NUM_QUEUES-1:0]            w_s_tlast;
  logic [W_WORD-1:0]                w_fifo_dout [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]            w_full;
  logic [NUM_QUEUES-1:0]            w_empty;
  logic [NUM_QUEUES-1:0]            w_rd_en;

  logic [C_M_AXIS_DATA_WIDTH-1:0]   w_head_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] w_head_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  w_head_user;
  logic                             w_head_last;

  arb_state_t       r_state, w_state_nxt;
  logic [QID_W-1:0] r_grant, w_grant_nxt;
  logic [QID_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [QID_W-1:0] w_idx;
  logic [QID_W-1:0] w_pick;
  logic             w_found;
  logic             w_out_hs;

  assign w_s_tdata[0] = S_AXIS_0_TDATA;
  assign w_s_tdata[1] = S_AXIS_1_TDATA;
  assign w_s_tdata[2] = S_AXIS_2_TDATA;
  assign w_s_tdata[3] = S_AXIS_3_TDATA;
  assign w_s_tdata[4] = S_AXIS_4_TDATA;
  assign w_s_tstrb[0] = S_AXIS_0_TSTRB;
  assign w_s_tstrb[1] = S_AXIS_1_TSTRB;
  assign w_s_tstrb[2] = S_AXIS_2_TSTRB;
  assign w_s_tstrb[3] = S_AXIS_3_TSTRB;
  assign w_s_tstrb[4] = S_AXIS_4_TSTRB;
  assign w_s_tuser[0] = S_AXIS_0_TUSER;
  assign w_s_tuser[1] = S_AXIS_1_TUSER;
  assign w_s_tuser[2] = S_AXIS_2_TUSER;
  assign w_s_tuser[3] = S_AXIS_3_TUSER;
  assign w_s_tuser[4] = S_AXIS_4_TUSER;
  assign w_s_tvalid   = {S_AXIS_4_TVALID, S_AXIS_3_TVALID, S_AXIS_2_TVALID,
                         S_AXIS_1_TVALID, S_AXIS_0_TVALID};
  assign w_s_tlast    = {S_AXIS_4_TLAST, S_AXIS_3_TLAST, S_AXIS_2_TLAST,
                         S_AXIS_1_TLAST, S_AXIS_0_TLAST};

  assign S_AXIS_0_TREADY = !w_full[0];
  assign S_AXIS_1_TREADY = !w_full[1];
  assign S_AXIS_2_TREADY = !w_full[2];
  assign S_AXIS_3_TREADY = !w_full[3];
  assign S_AXIS_4_TREADY = !w_full[4];

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    assign w_rd_en[q] = w_out_hs && (r_grant == QID_W'(q));

    nf10_axis_fallthrough_fifo #(
      .WIDTH      (W_WORD),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .i_clk     (S_AXI_ACLK),
      .i_rst_n   (S_AXI_ARESETN),
      .i_wr_en   (w_s_tvalid[q] && !w_full[q]),
      .i_wr_data ({w_s_tdata[q], w_s_tstrb[q], w_s_tuser[q], w_s_tlast[q]}),
      .i_rd_en   (w_rd_en[q]),
      .o_rd_data (w_fifo_dout[q]),
      .o_full    (w_full[q]),
      .o_empty   (w_empty[q])
    );
  end

  assign {w_head_data, w_head_strb, w_head_user, w_head_last} = w_fifo_dout[r_grant];
  assign w_out_hs = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state      <= PICK;
      r_grant      <= '0;
      r_last_grant <= QID_W'(NUM_QUEUES - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_found          = 1'b0;
    w_pick           = r_last_grant;
    w_idx            = '0;
    M_AXIS_TVALID    = 1'b0;
    M_AXIS_TDATA     = '0;
    M_AXIS_TSTRB     = '0;
    M_AXIS_TUSER     = '0;
    M_AXIS_TLAST     = 1'b0;

    // last_grant itself is scanned last, so a lone busy port can be regranted
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      w_idx = rr_index(r_last_grant, QID_W'(k));
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end

    case (r_state)
      PICK: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        // grant is held across an empty FIFO so a partial packet is never interleaved
        M_AXIS_TVALID = !w_empty[r_grant];
        M_AXIS_TDATA  = w_head_data;
        M_AXIS_TSTRB  = w_head_strb;
        M_AXIS_TUSER  = w_head_user;
        M_AXIS_TLAST  = w_head_last;
        if (w_out_hs && w_head_last) begin
          w_last_grant_nxt = r_grant;
          w_state_nxt      = PICK;
        end
      end
      default: w_state_nxt = PICK;
    endcase
  end

`ifdef INPUT_ARB_STATS_EN
  logic [31:0] r_pkt_cnt;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                 r_pkt_cnt <= '0;
    else if (w_out_hs && M_AXIS_TLAST)  r_pkt_cnt <= r_pkt_cnt + 32'd1;
  end

  assign STAT_PKT_CNT = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_nf10_switch_input_arbiter.sv
module tb_nf10_switch_input_arbiter;
  import nf10_switch_input_arbiter_pkg::*;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } word_t;
  typedef word_t wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] s_tdata  [5];
  logic [31:0]  s_tstrb  [5];
  logic [127:0] s_tuser  [5];
  logic         s_tvalid [5];
  logic         s_tlast  [5];
  logic         s_tready [5];
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
`ifdef INPUT_ARB_STATS_EN
  logic [31:0]  stat_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc4  = 0;

  word_t sb_q[$];
  int    rise_q[$];
  int    start_q[$];
  int    end_q[$];

  nf10_switch_input_arbiter dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .S_AXIS_0_TDATA  (s_tdata[0]),
    .S_AXIS_0_TSTRB  (s_tstrb[0]),
    .S_AXIS_0_TUSER  (s_tuser[0]),
    .S_AXIS_0_TVALID (s_tvalid[0]),
    .S_AXIS_0_TREADY (s_tready[0]),
    .S_AXIS_0_TLAST  (s_tlast[0]),
    .S_AXIS_1_TDATA  (s_tdata[1]),
    .S_AXIS_1_TSTRB  (s_tstrb[1]),
    .S_AXIS_1_TUSER  (s_tuser[1]),
    .S_AXIS_1_TVALID (s_tvalid[1]),
    .S_AXIS_1_TREADY (s_tready[1]),
    .S_AXIS_1_TLAST  (s_tlast[1]),
    .S_AXIS_2_TDATA  (s_tdata[2]),
    .S_AXIS_2_TSTRB  (s_tstrb[2]),
    .S_AXIS_2_TUSER  (s_tuser[2]),
    .S_AXIS_2_TVALID (s_tvalid[2]),
    .S_AXIS_2_TREADY (s_tready[2]),
    .S_AXIS_2_TLAST  (s_tlast[2]),
    .S_AXIS_3_TDATA  (s_tdata[3]),
    .S_AXIS_3_TSTRB  (s_tstrb[3]),
    .S_AXIS_3_TUSER  (s_tuser[3]),
    .S_AXIS_3_TVALID (s_tvalid[3]),
    .S_AXIS_3_TREADY (s_tready[3]),
    .S_AXIS_3_TLAST  (s_tlast[3]),
    .S_AXIS_4_TDATA  (s_tdata[4]),
    .S_AXIS_4_TSTRB  (s_tstrb[4]),
    .S_AXIS_4_TUSER  (s_tuser[4]),
    .S_AXIS_4_TVALID (s_tvalid[4]),
    .S_AXIS_4_TREADY (s_tready[4]),
    .S_AXIS_4_TLAST  (s_tlast[4]),
    .M_AXIS_TDATA    (m_tdata),
    .M_AXIS_TSTRB    (m_tstrb),
    .M_AXIS_TUSER    (m_tuser),
    .M_AXIS_TVALID   (m_tvalid),
    .M_AXIS_TREADY   (m_tready),
    .M_AXIS_TLAST    (m_tlast)
`ifdef INPUT_ARB_STATS_EN
    ,
    .STAT_PKT_CNT    (stat_cnt)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Egress monitor: pops the scoreboard on every handshake, checks hold-while-stalled.
  logic         prev_stall = 1'b0;
  logic         prev_valid = 1'b0;
  logic         in_pkt     = 1'b0;
  logic [255:0] prev_d;
  logic [127:0] prev_u;
  always @(negedge clk) begin
    word_t got, exp;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      in_pkt     = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tuser !== prev_u) begin
          bad++;
          $display("FAIL hold_while_stalled: got valid=%b data=%h, required valid=1 data=%h",
                   m_tvalid, m_tdata, prev_d);
        end
      end
      if (m_tvalid && !prev_valid) rise_q.push_back(cyc);
      if (m_tvalid && m_tready) begin
        got = {m_tdata, m_tstrb, m_tuser, m_tlast};
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h, required no output", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL egress_word: got %h required %h", got, exp);
          end
        end
        if (!in_pkt) start_q.push_back(cyc);
        in_pkt = 1'b1;
        if (m_tlast) begin
          end_q.push_back(cyc);
          in_pkt = 1'b0;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_valid = m_tvalid;
      prev_d     = m_tdata;
      prev_u     = m_tuser;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic word_t mk_word(input int p, input int idx, input bit last);
    word_t w;
    for (int k = 0; k < 8; k++) w.d[k*32 +: 32] = $urandom;
    w.d[255:248]          = 8'(p);
    w.s                   = $urandom;
    w.u                   = '0;
    w.u[LEN_POS +: 16]    = 16'(idx + 1);
    w.u[SRC_POS +: 8]     = 8'(p);
    w.u[DST_POS +: 8]     = 8'($urandom_range(0, 255));
    w.u[127:96]           = $urandom;
    w.l                   = last;
    return w;
  endfunction

  function automatic wq_t build_pkt(input int p, input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(mk_word(p, i, i == n - 1));
    return q;
  endfunction

  task automatic push_pkt(input wq_t pkt);
    foreach (pkt[i]) sb_q.push_back(pkt[i]);
  endtask

  // Entered at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_word(input int p, input word_t w, output int hs);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    hs   = -1;
    s_tdata[p]  = w.d;
    s_tstrb[p]  = w.s;
    s_tuser[p]  = w.u;
    s_tlast[p]  = w.l;
    s_tvalid[p] = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_tready[p]) begin
        hs   = cyc;
        done = 1'b1;
      end else begin
        n++;
        if (n > 400) begin
          total++;
          bad++;
          $display("FAIL send_timeout port%0d: ready=0 after %0d cycles, required 1", p, n);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    s_tvalid[p] = 1'b0;
    s_tlast[p]  = 1'b0;
  endtask

  task automatic send_pkt(input int p, input wq_t pkt);
    int hs;
    foreach (pkt[i]) send_word(p, pkt[i], hs);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b last=%b data=%h, required all 0", m_tvalid, m_tlast, m_tdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      total++;
      if (s_tready[p] !== 1'b1) begin
        bad++;
        $display("FAIL reset_tready port%0d: got %b required 1", p, s_tready[p]);
      end
    end
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL idle_tvalid: got %b required 0", m_tvalid);
    end
`ifdef INPUT_ARB_STATS_EN
    total++;
    if (stat_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_stat: got %0d required 0", stat_cnt);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    wq_t pkt;
    int  hs0, hs, r;
    rise_q.delete();
    pkt = build_pkt(2, 3);
    push_pkt(pkt);
    send_word(2, pkt[0], hs0);
    send_word(2, pkt[1], hs);
    send_word(2, pkt[2], hs);
    drain();
    r = (rise_q.size() > 0) ? rise_q[0] : -1;
    total++;
    if (r !== hs0 + 2) begin
      bad++;
      $display("FAIL first_latency: got tvalid at cycle %0d, required %0d", r, hs0 + 2);
    end
  endtask

  task automatic test_rr_order();
    wq_t p0a, p1, p3, p0b;
    int  g;
    apply_reset();
    p0a = build_pkt(0, 2);
    p1  = build_pkt(1, 2);
    p3  = build_pkt(3, 2);
    p0b = build_pkt(0, 2);
    push_pkt(p0a);
    push_pkt(p1);
    push_pkt(p3);
    push_pkt(p0b);
    start_q.delete();
    end_q.delete();
    fork
      begin send_pkt(0, p0a); send_pkt(0, p0b); end
      send_pkt(1, p1);
      send_pkt(3, p3);
    join
    drain();
    total++;
    if (start_q.size() != 4) begin
      bad++;
      $display("FAIL rr_packet_count: got %0d required 4", start_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      g = (start_q.size() > i + 1 && end_q.size() > i) ? start_q[i+1] - end_q[i] : -1;
      total++;
      if (g != 2) begin
        bad++;
        $display("FAIL rr_gap%0d: got %0d cycles end-to-start, required 2", i, g);
      end
    end
  endtask

  task automatic test_backpressure();
    wq_t pkt;
    m_tready = 1'b0;
    acc4     = 0;
    pkt = build_pkt(4, 20);
    push_pkt(pkt);
    fork
      begin
        int hs;
        foreach (pkt[i]) begin
          send_word(4, pkt[i], hs);
          acc4++;
        end
      end
      begin
        repeat (24) @(posedge clk);
        @(negedge clk);
        total++;
        if (acc4 != 16) begin
          bad++;
          $display("FAIL bp_accepted: got %0d words, required 16", acc4);
        end
        total++;
        if (s_tready[4] !== 1'b0) begin
          bad++;
          $display("FAIL bp_tready: got %b required 0", s_tready[4]);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    total++;
    if (acc4 != 20) begin
      bad++;
      $display("FAIL bp_total: got %0d words accepted, required 20", acc4);
    end
  endtask

  task automatic test_gap_no_interleave();
    wq_t p1, p0;
    apply_reset();
    p1 = build_pkt(1, 2);
    p0 = build_pkt(0, 2);
    push_pkt(p1);
    push_pkt(p0);
    rise_q.delete();
    fork
      begin
        int hs;
        send_word(1, p1[0], hs);
        repeat (5) @(posedge clk);
        #1;
        send_word(1, p1[1], hs);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        send_pkt(0, p0);
      end
    join
    drain();
    total++;
    if (rise_q.size() != 3) begin
      bad++;
      $display("FAIL gap_valid_rises: got %0d, required 3", rise_q.size());
    end
  endtask

  task automatic test_reset_mid();
    wq_t pkt, nw;
    int  hs;
    apply_reset();
    m_tready = 1'b0;
    pkt = build_pkt(3, 3);
    send_word(3, pkt[0], hs);
    send_word(3, pkt[1], hs);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL midpkt_valid: got %b required 1", m_tvalid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
      bad++;
      $display("FAIL midpkt_reset_outputs: got valid=%b last=%b data=%h, required all 0",
               m_tvalid, m_tlast, m_tdata);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (s_tready[3] !== 1'b1 || m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL midpkt_after_reset: got tready=%b tvalid=%b, required 1 and 0", s_tready[3], m_tvalid);
    end
    @(posedge clk);
    #1;
    nw = build_pkt(3, 2);
    push_pkt(nw);
    send_pkt(3, nw);
    drain();
  endtask

  task automatic test_stats();
    wq_t pkt;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      pkt = build_pkt(i % 5, (i % 3) + 1);
      push_pkt(pkt);
      send_pkt(i % 5, pkt);
      drain();
    end
`ifdef INPUT_ARB_STATS_EN
    total++;
    if (stat_cnt !== 32'd7) begin
      bad++;
      $display("FAIL stat_count: got %0d required 7", stat_cnt);
    end
    apply_reset();
    @(negedge clk);
    total++;
    if (stat_cnt !== 32'd0) begin
      bad++;
      $display("FAIL stat_after_reset: got %0d required 0", stat_cnt);
    end
`endif
  endtask

  initial begin
    for (int p = 0; p < 5; p++) begin
      s_tdata[p]  = '0;
      s_tstrb[p]  = '0;
      s_tuser[p]  = '0;
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
    end
    m_tready = 1'b1;
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_gap_no_interleave();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
